rx_status_monitor_mp: RTL and testbench

Multi-port successor to the single-port host RX status monitor. For each of NUM_PORTS root-hub ports it:
- debounces the line connect state;
- produces one-cycle connection-change and resume-edge pulses;
- holds them in sticky write-1-to-clear status bits with overrun flags;
- drives a single maskable interrupt to the host controller register block.

Sits between the per-port line-state decoders and the host controller's status/interrupt registers.

---
 rtl/rx_status_monitor_mp.sv | 107 ++++++++++
 tb/tb_rx_status_monitor_mp.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/rx_status_monitor_mp.sv
// Multi-port root-hub RX status monitor: per-port connect-state debounce, resume
// edge detection, sticky write-1-to-clear status with overrun, and a maskable irq.
module rx_status_monitor_mp #(
  parameter int unsigned NUM_PORTS       = 4,
  parameter int unsigned STATE_W         = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PORTS*STATE_W-1:0]   connectStateIn,
  input  logic [NUM_PORTS-1:0]           resumeDetectedIn,
  input  logic [2*NUM_PORTS-1:0]         statusClearIn,
  input  logic [2*NUM_PORTS-1:0]         intEnableIn,
  output logic [NUM_PORTS*STATE_W-1:0]   connectStateOut,
  output logic [NUM_PORTS-1:0]           connectionEventOut,
  output logic [NUM_PORTS-1:0]           resumeIntOut,
  output logic [2*NUM_PORTS-1:0]         statusOut,
  output logic [2*NUM_PORTS-1:0]         overrunOut,
  output logic                           irqOut
);

  localparam int unsigned CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned STS_W    = 2 * NUM_PORTS;

  logic [STATE_W-1:0] accepted      [NUM_PORTS];
  logic [STATE_W-1:0] candidate     [NUM_PORTS];
  logic [CNT_W-1:0]   debounceCnt   [NUM_PORTS];

  logic [STATE_W-1:0] acceptedNext  [NUM_PORTS];
  logic [STATE_W-1:0] candidateNext [NUM_PORTS];
  logic [CNT_W-1:0]   debounceNext  [NUM_PORTS];
  logic [CNT_W-1:0]   sampleCount   [NUM_PORTS];
  logic [NUM_PORTS-1:0] connectEventNext;

  logic [NUM_PORTS-1:0] resumePrev;
  logic [STS_W-1:0]     statusEvent;
  logic [STS_W-1:0]     statusNext;
  logic [STS_W-1:0]     overrunNext;

  // Accepted state is exported directly; raw input never reaches the output.
  for (genvar gp = 0; gp < NUM_PORTS; gp++) begin : gen_state_out
    assign connectStateOut[gp*STATE_W +: STATE_W] = accepted[gp];
  end

  // Debounce: a new value is accepted on its DEBOUNCE_CYCLES-th consecutive sample.
  always_comb begin
    connectEventNext = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      acceptedNext[p]  = accepted[p];
      candidateNext[p] = candidate[p];
      debounceNext[p]  = debounceCnt[p];
      sampleCount[p]   = '0;
      if (connectStateIn[p*STATE_W +: STATE_W] == accepted[p]) begin
        debounceNext[p] = '0;
      end else begin
        sampleCount[p]   = (connectStateIn[p*STATE_W +: STATE_W] != candidate[p])
                           ? CNT_W'(1) : debounceCnt[p] + CNT_W'(1);
        candidateNext[p] = connectStateIn[p*STATE_W +: STATE_W];
        if (sampleCount[p] == CNT_W'(DEBOUNCE_CYCLES)) begin
          acceptedNext[p]     = connectStateIn[p*STATE_W +: STATE_W];
          debounceNext[p]     = '0;
          connectEventNext[p] = 1'b1;
        end else begin
          debounceNext[p] = sampleCount[p];
        end
      end
    end
  end

  // Sticky status: a coincident event beats its clear and leaves overrun untouched.
  always_comb begin
    statusEvent = {resumeIntOut, connectionEventOut};
    statusNext  = statusEvent | (statusOut & ~statusClearIn);
    overrunNext = (overrunOut & ~statusClearIn)
                | (statusEvent & statusOut & ~statusClearIn)
                | (statusEvent & statusClearIn & overrunOut);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        accepted[p]    <= '0;
        candidate[p]   <= '0;
        debounceCnt[p] <= '0;
      end
      connectionEventOut <= '0;
      resumeIntOut       <= '0;
      resumePrev         <= '1;
      statusOut          <= '0;
      overrunOut         <= '0;
      irqOut             <= 1'b0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        accepted[p]    <= acceptedNext[p];
        candidate[p]   <= candidateNext[p];
        debounceCnt[p] <= debounceNext[p];
      end
      connectionEventOut <= connectEventNext;
      resumeIntOut       <= resumeDetectedIn & ~resumePrev;
      resumePrev         <= resumeDetectedIn;
      statusOut          <= statusNext;
      overrunOut         <= overrunNext;
      irqOut             <= |(statusOut & intEnableIn);
    end
  end

endmodule

// File: tb/tb_rx_status_monitor_mp.sv
// Randomized and directed bench for rx_status_monitor_mp against a run-length
// behavioural model of debounce, resume edges and sticky status.
module tb_rx_status_monitor_mp;

  localparam int unsigned NP = 4;
  localparam int unsigned SW = 2;
  localparam int unsigned DC = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP*SW-1:0]  connectStateIn;
  logic [NP-1:0]     resumeDetectedIn;
  logic [2*NP-1:0]   statusClearIn;
  logic [2*NP-1:0]   intEnableIn;
  logic [NP*SW-1:0]  connectStateOut;
  logic [NP-1:0]     connectionEventOut;
  logic [NP-1:0]     resumeIntOut;
  logic [2*NP-1:0]   statusOut;
  logic [2*NP-1:0]   overrunOut;
  logic              irqOut;

  rx_status_monitor_mp #(
    .NUM_PORTS(NP), .STATE_W(SW), .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk(clk), .rst(rst),
    .connectStateIn(connectStateIn), .resumeDetectedIn(resumeDetectedIn),
    .statusClearIn(statusClearIn), .intEnableIn(intEnableIn),
    .connectStateOut(connectStateOut), .connectionEventOut(connectionEventOut),
    .resumeIntOut(resumeIntOut), .statusOut(statusOut),
    .overrunOut(overrunOut), .irqOut(irqOut)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state
  logic [SW-1:0]   accM    [NP];
  logic [SW-1:0]   lastRaw [NP];
  int              runLen  [NP];
  logic [NP-1:0]   evM, resM, prevM;
  logic [2*NP-1:0] statusM, ovrM;
  logic            irqM;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int p = 0; p < NP; p++) begin
      accM[p]    = '0;
      lastRaw[p] = '0;
      runLen[p]  = 0;
    end
    evM = '0; resM = '0; prevM = '1;
    statusM = '0; ovrM = '0; irqM = 1'b0;
  endtask

  // One clock edge of the reference behaviour, using the inputs sampled at that edge.
  task automatic modelEdge();
    logic [2*NP-1:0] evVec;
    logic [SW-1:0]   raw;
    if (rst) begin
      modelReset();
      return;
    end
    evVec = {resM, evM};
    irqM  = |(statusM & intEnableIn);
    for (int b = 0; b < 2*NP; b++) begin
      if (evVec[b]) begin
        if (statusM[b] && !statusClearIn[b]) ovrM[b] = 1'b1;
        statusM[b] = 1'b1;
      end else if (statusClearIn[b]) begin
        statusM[b] = 1'b0;
        ovrM[b]    = 1'b0;
      end
    end
    for (int p = 0; p < NP; p++) begin
      resM[p]  = resumeDetectedIn[p] && !prevM[p];
      prevM[p] = resumeDetectedIn[p];
      raw = connectStateIn[p*SW +: SW];
      if (runLen[p] > 0 && raw == lastRaw[p]) runLen[p]++;
      else runLen[p] = 1;
      lastRaw[p] = raw;
      evM[p] = 1'b0;
      if (raw != accM[p] && runLen[p] >= DC) begin
        accM[p] = raw;
        evM[p]  = 1'b1;
      end
    end
  endtask

  task automatic compareAll();
    logic [NP*SW-1:0] stateExp;
    for (int p = 0; p < NP; p++) stateExp[p*SW +: SW] = accM[p];
    checkVal("connectState", 64'(connectStateOut),    64'(stateExp));
    checkVal("connectEvent", 64'(connectionEventOut), 64'(evM));
    checkVal("resumeInt",    64'(resumeIntOut),       64'(resM));
    checkVal("status",       64'(statusOut),          64'(statusM));
    checkVal("overrun",      64'(overrunOut),         64'(ovrM));
    checkVal("irq",          64'(irqOut),             64'(irqM));
  endtask

  task automatic step();
    @(posedge clk);
    modelEdge();
    #1;
    compareAll();
  endtask

  task automatic setRaw(input int p, input logic [SW-1:0] v);
    connectStateIn[p*SW +: SW] = v;
  endtask

  int pulses;

  initial begin
    rst = 1'b1;
    connectStateIn = '0; resumeDetectedIn = '0; statusClearIn = '0; intEnableIn = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    compareAll();
    rst = 1'b0;

    // Port 0 connects: event on the DC-th sampling edge, status one cycle later
    setRaw(0, 2'd1);
    repeat (DC-1) step();
    checkVal("p0EventEarly", 64'(connectionEventOut[0]), 64'(0));
    step();
    checkVal("p0EventAtDC", 64'(connectionEventOut[0]), 64'(1));
    checkVal("p0StateOut", 64'(connectStateOut[1:0]), 64'(1));
    step();
    checkVal("p0Status", 64'(statusOut[0]), 64'(1));
    checkVal("p0EventOnce", 64'(connectionEventOut[0]), 64'(0));

    // Port 1 glitch shorter than DC, then a real run
    setRaw(1, 2'd2);
    pulses = 0;
    repeat (DC-1) begin step(); pulses += int'(connectionEventOut[1]); end
    setRaw(1, 2'd0);
    step(); pulses += int'(connectionEventOut[1]);
    checkVal("p1GlitchNoEvent", 64'(pulses), 64'(0));
    setRaw(1, 2'd2);
    repeat (DC-1) step();
    checkVal("p1NotYet", 64'(connectionEventOut[1]), 64'(0));
    step();
    checkVal("p1Event", 64'(connectionEventOut[1]), 64'(1));

    // Port 2 resume: one pulse per rising edge, irq via enable, then overrun and clear
    intEnableIn[NP+2] = 1'b1;
    resumeDetectedIn[2] = 1'b1;
    pulses = 0;
    repeat (10) begin step(); pulses += int'(resumeIntOut[2]); end
    checkVal("p2ResumePulses", 64'(pulses), 64'(1));
    checkVal("p2ResumeStatus", 64'(statusOut[NP+2]), 64'(1));
    checkVal("irqHigh", 64'(irqOut), 64'(1));
    resumeDetectedIn[2] = 1'b0;
    repeat (2) step();
    resumeDetectedIn[2] = 1'b1;
    repeat (3) step();
    checkVal("p2Overrun", 64'(overrunOut[NP+2]), 64'(1));
    statusClearIn[NP+2] = 1'b1;
    step();
    statusClearIn = '0;
    checkVal("p2ClearStatus", 64'(statusOut[NP+2]), 64'(0));
    checkVal("p2ClearOverrun", 64'(overrunOut[NP+2]), 64'(0));
    step();
    checkVal("irqDropped", 64'(irqOut), 64'(0));
    resumeDetectedIn[2] = 1'b0;

    // Port 3: build an overrun, then clear coincident with a third event
    setRaw(3, 2'd1);
    repeat (DC+1) step();
    setRaw(3, 2'd2);
    repeat (DC+1) step();
    checkVal("p3OverrunSet", 64'(overrunOut[3]), 64'(1));
    setRaw(3, 2'd3);
    repeat (DC) step();
    statusClearIn[3] = 1'b1;
    step();
    statusClearIn = '0;
    checkVal("p3SetBeatsClear", 64'(statusOut[3]), 64'(1));
    checkVal("p3OverrunKept", 64'(overrunOut[3]), 64'(1));

    // Async reset with devices present and resume high everywhere
    connectStateIn = {NP{2'b01}};
    resumeDetectedIn = '1;
    #2;
    rst = 1'b1;
    modelReset();
    #1;
    compareAll();
    repeat (2) step();
    rst = 1'b0;
    pulses = 0;
    repeat (DC-1) begin step(); pulses += int'(|resumeIntOut); end
    checkVal("rstNoEventYet", 64'(connectionEventOut), 64'(0));
    step(); pulses += int'(|resumeIntOut);
    checkVal("rstAllEvents", 64'(connectionEventOut), 64'({NP{1'b1}}));
    checkVal("rstNoResume", 64'(pulses), 64'(0));

    // Randomized traffic
    intEnableIn = 2*NP'($urandom);
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(11) == 0) setRaw(p, SW'($urandom));
        if ($urandom_range(5) == 0) resumeDetectedIn[p] = ~resumeDetectedIn[p];
      end
      statusClearIn = ($urandom_range(3) == 0) ? 2*NP'($urandom) : '0;
      if ($urandom_range(49) == 0) intEnableIn = 2*NP'($urandom);
      if ($urandom_range(499) == 0) begin
        rst = 1'b1;
        modelReset();
        #1;
        compareAll();
        step();
        rst = 1'b0;
      end else begin
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
